// File: rtl/sram_scrub_pkg.sv
// Shared types and constants for the SRAM init/scrub controller.
package sram_scrub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SCRUB,
        DRAIN
    } state_e;

    localparam int unsigned LfsrW = 32;
    // Galois right-shift taps for x^32 + x^22 + x^2 + x + 1
    localparam logic [LfsrW-1:0] LfsrPoly = 32'h8020_0003;
    localparam int unsigned ErrCntW = 16;

    function automatic logic [LfsrW-1:0] lfsr_step(input logic [LfsrW-1:0] s);
        return s[0] ? ((s >> 1) ^ LfsrPoly) : (s >> 1);
    endfunction

endpackage

// File: rtl/sram_scrub_lfsr.sv
// Galois LFSR that generates the init-sweep write pattern; reloadable with its seed.
module sram_scrub_lfsr
    import sram_scrub_pkg::*;
#(
    parameter logic [LfsrW-1:0] Seed = 32'h1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    output logic [LfsrW-1:0] state_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_o <= Seed;
        end else if (load_i) begin
            state_o <= Seed;
        end else if (step_i) begin
            state_o <= lfsr_step(state_o);
        end
    end

endmodule

// File: rtl/sram_scrub_ctrl.sv
// SRAM init/scrub sweep controller with error accounting.
// Define SRAM_SCRUB_LFSR_EN to fill memory with an LFSR pattern instead of zeros.
module sram_scrub_ctrl
    import sram_scrub_pkg::*;
#(
    parameter int unsigned Depth    = 16384,
    parameter int unsigned Width    = 32,
    parameter logic [31:0] LfsrSeed = 32'h1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     init_req_i,
    input  logic                     scrub_req_i,
    input  logic                     key_valid_i,
    output logic                     req_o,
    input  logic                     gnt_i,
    output logic                     write_o,
    output logic [$clog2(Depth)-1:0] addr_o,
    output logic [Width-1:0]         wdata_o,
    output logic [Width-1:0]         wmask_o,
    input  logic                     rvalid_i,
    input  logic [1:0]               rerror_i,
    input  logic [31:0]              raddr_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [ErrCntW-1:0]       corr_cnt_o,
    output logic                     uncorr_o,
    output logic [31:0]              err_addr_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);

    if (Depth < 4 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("Depth must be a power of two and at least 4");
    end
    if (Width == 0 || (Width % 8) != 0) begin : g_bad_width
        $error("Width must be a nonzero multiple of 8");
    end
    if (LfsrSeed == '0) begin : g_bad_seed
        $error("LfsrSeed must be nonzero");
    end

    state_e     state;
    logic [1:0] outs;
    logic [1:0] outs_nxt;
    logic       xfer;
    logic       rd_xfer;
    logic       rsp;

    assign req_o   = (state == INIT || state == SCRUB) && key_valid_i && (outs < 2'd2);
    assign write_o = (state == INIT);
    assign wmask_o = (state == INIT) ? '1 : '0;
    assign xfer    = req_o && gnt_i;
    assign rd_xfer = xfer && (state == SCRUB);
    assign rsp     = rvalid_i && (state != IDLE) && (outs != 2'd0);

    // A read issued and a response returned in the same cycle cancel out.
    always_comb begin
        outs_nxt = outs;
        if (rd_xfer && !rsp) begin
            outs_nxt = outs + 2'd1;
        end else if (!rd_xfer && rsp) begin
            outs_nxt = outs - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            addr_o     <= '0;
            outs       <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            corr_cnt_o <= '0;
            uncorr_o   <= 1'b0;
            err_addr_o <= '0;
        end else begin
            done_o <= 1'b0;
            outs   <= outs_nxt;
            case (state)
                IDLE: begin
                    if (init_req_i || scrub_req_i) begin
                        state      <= init_req_i ? INIT : SCRUB;
                        busy_o     <= 1'b1;
                        addr_o     <= '0;
                        corr_cnt_o <= '0;
                        uncorr_o   <= 1'b0;
                        err_addr_o <= '0;
                    end
                end
                INIT: begin
                    if (xfer) begin
                        if (addr_o == LastAddr) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            addr_o <= addr_o + AW'(1);
                        end
                    end
                end
                SCRUB: begin
                    if (xfer) begin
                        if (addr_o == LastAddr) begin
                            state <= DRAIN;
                        end else begin
                            addr_o <= addr_o + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (outs_nxt == 2'd0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (rsp) begin
                if (rerror_i[0] && corr_cnt_o != '1) begin
                    corr_cnt_o <= corr_cnt_o + ErrCntW'(1);
                end
                if (rerror_i[1]) begin
                    uncorr_o <= 1'b1;
                    if (!uncorr_o) begin
                        err_addr_o <= raddr_i;
                    end
                end
            end
        end
    end

`ifdef SRAM_SCRUB_LFSR_EN
    localparam int unsigned Reps = (Width + LfsrW - 1) / LfsrW;

    logic [LfsrW-1:0]      lfsr_q;
    logic [Reps*LfsrW-1:0] lfsr_rep;

    sram_scrub_lfsr #(
        .Seed(LfsrSeed)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (state == IDLE && init_req_i),
        .step_i (xfer && state == INIT),
        .state_o(lfsr_q)
    );

    assign lfsr_rep = {Reps{lfsr_q}};
    // Gated so the pattern never leaks onto the bus outside an init sweep.
    assign wdata_o  = (state == INIT) ? lfsr_rep[Width-1:0] : '0;
`else
    assign wdata_o = '0;
`endif

endmodule

// File: tb/tb_sram_scrub_ctrl.sv
// Scoreboard bench for sram_scrub_ctrl (Depth=16, Width=32) with a responding memory model.
module tb_sram_scrub_ctrl;
    import sram_scrub_pkg::*;

    localparam int unsigned Depth = 16;
    localparam int unsigned Width = 32;
    localparam int unsigned AW    = 4;
    localparam logic [31:0] Seed  = 32'h1;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             init_req_i = 1'b0;
    logic             scrub_req_i = 1'b0;
    logic             key_valid_i = 1'b1;
    logic             req_o;
    logic             gnt_i = 1'b1;
    logic             write_o;
    logic [AW-1:0]    addr_o;
    logic [Width-1:0] wdata_o;
    logic [Width-1:0] wmask_o;
    logic             rvalid_i = 1'b0;
    logic [1:0]       rerror_i = 2'b00;
    logic [31:0]      raddr_i = '0;
    logic             busy_o;
    logic             done_o;
    logic [15:0]      corr_cnt_o;
    logic             uncorr_o;
    logic [31:0]      err_addr_o;

    sram_scrub_ctrl #(
        .Depth(Depth),
        .Width(Width),
        .LfsrSeed(Seed)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .init_req_i(init_req_i), .scrub_req_i(scrub_req_i),
        .key_valid_i(key_valid_i), .req_o(req_o), .gnt_i(gnt_i), .write_o(write_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .wmask_o(wmask_o), .rvalid_i(rvalid_i),
        .rerror_i(rerror_i), .raddr_i(raddr_i), .busy_o(busy_o), .done_o(done_o),
        .corr_cnt_o(corr_cnt_o), .uncorr_o(uncorr_o), .err_addr_o(err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic             wr;
        logic [AW-1:0]    addr;
        logic [Width-1:0] wdata;
        logic [Width-1:0] wmask;
    } xfer_t;

    typedef struct {
        logic [15:0] corr;
        logic        uncorr;
        logic [31:0] err_addr;
        int          rsp;
    } done_t;

    xfer_t         exp_q[$];
    done_t         done_q[$];
    logic [AW-1:0] pending[$];
    logic [1:0]    err_map[Depth];
    int            vectors = 0;
    int            miscompares = 0;
    int            rsp_count = 0;
    int            last_xfer = -1;
    bit            hold_rsp = 1'b0;
    bit            gnt_rand = 1'b0;
    bit            key_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory side: answers each granted read one cycle later, in order.
    always @(posedge clk_i) begin
        #1;
        if (rst_i) begin
            pending.delete();
            rvalid_i = 1'b0;
            rerror_i = 2'b00;
            raddr_i  = '0;
        end else begin
            if (!hold_rsp && pending.size() > 0) begin
                raddr_i  = {28'b0, pending[0]};
                rerror_i = err_map[pending[0]];
                rvalid_i = 1'b1;
                void'(pending.pop_front());
                rsp_count++;
            end else begin
                rvalid_i = 1'b0;
                rerror_i = 2'b00;
                raddr_i  = '0;
            end
            gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (key_rand) key_valid_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks request behaviour, pops transfers and sweep results.
    always @(negedge clk_i) begin
        int    outs;
        bit    issuing;
        bit    exp_req;
        xfer_t x;
        done_t d;
        if (!rst_i) begin
            outs    = pending.size() + (rvalid_i ? 1 : 0);
            issuing = (exp_q.size() > 0);
            exp_req = 1'b0;
            if (issuing) exp_req = key_valid_i && (exp_q[0].wr || outs < 2);
            chk("req", 32'(req_o), 32'(exp_req));
            if (issuing) chk("busy_in_sweep", 32'(busy_o), 32'd1);
            if (req_o && issuing) begin
                x = exp_q[0];
                chk("addr", 32'(addr_o), 32'(x.addr));
                chk("write", 32'(write_o), 32'(x.wr));
                chk("wdata", wdata_o, x.wdata);
                chk("wmask", wmask_o, x.wmask);
                if (gnt_i) begin
                    void'(exp_q.pop_front());
                    last_xfer = int'(x.addr);
                    if (!x.wr) pending.push_back(x.addr);
                end
            end
            if (done_o) begin
                if (done_q.size() == 0) begin
                    chk("done_spurious", 32'(done_o), 32'd0);
                end else begin
                    d = done_q.pop_front();
                    chk("corr_cnt", 32'(corr_cnt_o), 32'(d.corr));
                    chk("uncorr", 32'(uncorr_o), 32'(d.uncorr));
                    chk("err_addr", err_addr_o, d.err_addr);
                    chk("busy_at_done", 32'(busy_o), 32'd0);
                    chk("rsp_before_done", 32'(rsp_count), 32'(d.rsp));
                    chk("issue_left_at_done", 32'(exp_q.size()), 32'd0);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"}, 32'(req_o), 32'd0);
        chk({tag, "_write"}, 32'(write_o), 32'd0);
        chk({tag, "_addr"}, 32'(addr_o), 32'd0);
        chk({tag, "_wdata"}, wdata_o, 32'd0);
        chk({tag, "_wmask"}, wmask_o, 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_corr"}, 32'(corr_cnt_o), 32'd0);
        chk({tag, "_uncorr"}, 32'(uncorr_o), 32'd0);
        chk({tag, "_err_addr"}, err_addr_o, 32'd0);
    endtask

    // Pulses the start inputs and records what the sweep must produce.
    task automatic start(input bit do_init, input bit do_scrub);
        logic [31:0] w;
        done_t       d;
        bit          is_init;
        @(posedge clk_i); #1;
        init_req_i  = do_init;
        scrub_req_i = do_scrub;
        rsp_count   = 0;
        @(posedge clk_i); #1;
        init_req_i  = 1'b0;
        scrub_req_i = 1'b0;
        is_init = do_init;
        w = Seed;
        d.corr = 16'd0; d.uncorr = 1'b0; d.err_addr = '0; d.rsp = 0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (is_init) begin
`ifdef SRAM_SCRUB_LFSR_EN
                exp_q.push_back('{1'b1, AW'(i), w, '1});
                w = w[0] ? ((w >> 1) ^ LfsrPoly) : (w >> 1);
`else
                exp_q.push_back('{1'b1, AW'(i), '0, '1});
`endif
            end else begin
                exp_q.push_back('{1'b0, AW'(i), '0, '0});
                if (err_map[i][0] && d.corr != 16'hFFFF) d.corr++;
                if (err_map[i][1] && !d.uncorr) begin
                    d.uncorr = 1'b1;
                    d.err_addr = i;
                end
            end
        end
        if (!is_init) d.rsp = Depth;
        done_q.push_back(d);
    endtask

    task automatic wait_done();
        for (int c = 0; c < 800 && done_q.size() > 0; c++) @(posedge clk_i);
        if (done_q.size() > 0) begin
            chk("done_timeout", 32'(done_q.size()), 32'd0);
            exp_q.delete();
            done_q.delete();
            rst_i = 1'b1;
            repeat (2) @(posedge clk_i);
            #1 rst_i = 1'b0;
        end
        repeat (3) @(posedge clk_i);
    endtask

    task automatic clear_errs();
        for (int unsigned i = 0; i < Depth; i++) err_map[i] = 2'b00;
    endtask

    initial begin
        clear_errs();
        #2 rst_i = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Init sweep, grant tied high; a scrub pulse mid-sweep must be ignored.
        start(1'b1, 1'b0);
        repeat (3) @(posedge clk_i);
        #1 scrub_req_i = 1'b1;
        @(posedge clk_i); #1 scrub_req_i = 1'b0;
        wait_done();

        // Scrub, random grant, one correctable error.
        gnt_rand = 1'b1;
        err_map[5] = 2'b01;
        start(1'b0, 1'b1);
        wait_done();

        // Two uncorrectable errors: only the first address is kept.
        clear_errs();
        err_map[3] = 2'b10;
        err_map[9] = 2'b10;
        start(1'b0, 1'b1);
        wait_done();

        // Responses withheld: at most two reads in flight.
        clear_errs();
        gnt_rand = 1'b0;
        hold_rsp = 1'b1;
        start(1'b0, 1'b1);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        chk("stall_req", 32'(req_o), 32'd0);
        chk("stall_outstanding", 32'(pending.size()), 32'd2);
        hold_rsp = 1'b0;
        wait_done();

        // Key drops for cycles 4-10 of an init sweep.
        start(1'b1, 1'b0);
        for (int c = 0; c < 12; c++) begin
            key_valid_i = !(c >= 4 && c <= 10);
            @(posedge clk_i); #1;
        end
        key_valid_i = 1'b1;
        wait_done();

        // Both starts together: init wins.
        start(1'b1, 1'b1);
        wait_done();

        // Reset while the scrub is at address 7, then a clean restart.
        gnt_rand = 1'b1;
        last_xfer = -1;
        start(1'b0, 1'b1);
        for (int c = 0; c < 200 && last_xfer != 7; c++) @(negedge clk_i);
        chk("reached_addr7", 32'(last_xfer), 32'd7);
        #2 rst_i = 1'b1;
        exp_q.delete();
        done_q.delete();
        pending.delete();
        #1 check_all_zero("midsweep_reset");
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (6) @(posedge clk_i);
        start(1'b0, 1'b1);
        wait_done();

        // Randomised sweeps with flickering key and random error patterns.
        key_rand = 1'b1;
        for (int n = 0; n < 6; n++) begin
            for (int unsigned i = 0; i < Depth; i++)
                err_map[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 2) == 0) start(1'b1, 1'b0);
            else start(1'b0, 1'b1);
            wait_done();
        end
        key_rand = 1'b0;
        key_valid_i = 1'b1;
        repeat (3) @(posedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_scrub_ctrl.md
SRAM_SCRUB_CTRL -- requirements
Module: sram_scrub_ctrl

Interface
REQ-001 Parameter Depth, default 16384, SHALL set the word count (power of 2, >= 4).
REQ-002 Parameter Width, default 32, SHALL set the data width (multiple of 8).
REQ-003 Parameter LfsrSeed, default 32'h1, SHALL set the LFSR reset seed (nonzero).
REQ-004 Ports, name direction width meaning:
  clk_i  in  1  single clock.
  rst_i  in  1  asynchronous, active-high reset.
  init_req_i  in  1  start-init-sweep pulse.
  scrub_req_i  in  1  start-read-sweep pulse.
  key_valid_i  in  1  memory key valid.
  req_o  out  1  memory request.
  gnt_i  in  1  memory grant.
  write_o  out  1  1 = write, 0 = read.
  addr_o  out  vbits(Depth)  word address.
  wdata_o  out  Width  write data.
  wmask_o  out  Width  write mask.
  rvalid_i  in  1  read response valid.
  rerror_i  in  2  bit1 uncorrectable, bit0 correctable.
  raddr_i  in  32  address of the read response.
  busy_o  out  1  sweep in progress.
  done_o  out  1  one-cycle sweep-complete pulse.
  corr_cnt_o  out  16  correctable-error count.
  uncorr_o  out  1  sticky uncorrectable flag.
  err_addr_o  out  32  first uncorrectable address.

Function
REQ-005 FSM states SHALL be IDLE, INIT, SCRUB and DRAIN.
REQ-006 In IDLE, init_req_i SHALL go to INIT and scrub_req_i SHALL go to SCRUB; if both are high, INIT SHALL win.
REQ-007 On entry to INIT or SCRUB, the address SHALL be 0, corr_cnt_o SHALL be 0, uncorr_o SHALL be 0 and err_addr_o SHALL be 0.
REQ-008 Start pulses while busy_o=1 SHALL be ignored.
REQ-009 req_o SHALL be high in INIT or SCRUB only while key_valid_i=1 and outstanding reads < 2.
REQ-010 addr_o, write_o and wdata_o SHALL stay stable while req_o=1 and gnt_i=0.
REQ-011 A transfer SHALL occur when req_o and gnt_i are both high; the address SHALL increment by 1 on each transfer.
REQ-012 In INIT: write_o=1 and wmask_o all-ones.
REQ-013 In SCRUB: write_o=0 and wmask_o=0.
REQ-014 The outstanding-read counter (0..2) SHALL increment on each read transfer and decrement on rvalid_i; on the same cycle, the two SHALL cancel.
REQ-015 After the transfer at address Depth-1, INIT SHALL go directly to IDLE with done_o=1 for one cycle.
REQ-016 After the transfer at address Depth-1, SCRUB SHALL go to DRAIN.
REQ-017 DRAIN SHALL go to IDLE with done_o=1 on the cycle the outstanding count reaches 0.
REQ-018 The address SHALL NOT wrap past Depth-1.
REQ-019 When rvalid_i and rerror_i[0] are high, corr_cnt_o SHALL increment, saturating at 16'hFFFF.
REQ-020 When rvalid_i and rerror_i[1] are high, uncorr_o SHALL be set.
REQ-021 err_addr_o SHALL capture raddr_i only on the first uncorrectable error of a sweep.
REQ-022 If key_valid_i falls mid-sweep, req_o SHALL drop and resume later at the same address; the outstanding count, counters and state SHALL be kept.
REQ-023 busy_o SHALL be 1 in every state except IDLE.
REQ-024 The error counters SHALL hold their values in IDLE until the next start.

Reset
REQ-025 rst_i SHALL asynchronously force IDLE and set the address, outstanding count and LFSR to seed or zero.
REQ-026 Under rst_i, every output SHALL be 0 (err_addr_o and corr_cnt_o included).
REQ-027 A reset asserted mid-sweep SHALL abort the sweep with no done_o pulse.

Configuration
REQ-028 With SRAM_SCRUB_LFSR_EN defined, wdata_o SHALL come from a Galois LFSR replicated to Width.
REQ-029 With SRAM_SCRUB_LFSR_EN defined, the LFSR SHALL be reseeded to LfsrSeed on INIT entry and SHALL advance once per write transfer.
REQ-030 Without SRAM_SCRUB_LFSR_EN, wdata_o SHALL be constant 0 and no LFSR logic SHALL be present.

Structure
REQ-031 Package sram_scrub_pkg SHALL hold the state enum, the LFSR width (32), the LFSR polynomial constant and ErrCntW=16.
REQ-032 The LFSR SHALL be one sub-module, sram_scrub_lfsr, instantiated only under SRAM_SCRUB_LFSR_EN.

Verification (Depth=16, Width=32)
REQ-033 init_req_i pulse, gnt_i tied 1 -> 16 writes at addresses 0..15, then done_o high one cycle after the last write; busy_o falls the same cycle.
REQ-034 scrub_req_i pulse, gnt_i random, rvalid_i one cycle after grant, rerror_i=2'b01 on address 5 -> corr_cnt_o=1, uncorr_o=0, done_o only after the 16th rvalid.
REQ-035 scrub with rerror_i=2'b10 at raddr_i=3 and raddr_i=9 -> uncorr_o=1, err_addr_o=3.
REQ-036 rvalid_i withheld -> req_o stops after 2 outstanding reads and resumes on the next rvalid_i.
REQ-037 key_valid_i low for cycles 4-10 during init -> req_o=0 in that window, no address skipped, done_o after 16 writes.
REQ-038 rst_i asserted at address 7 of scrub -> all outputs 0 immediately; a later scrub_req_i restarts at address 0.
